// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Multi-cycle load/store sequencer sitting between instruction decode and
// data memory. It takes one request at a time, runs the memory handshake, and
// for loads writes the returned data into the register file for exactly one
// cycle. An access that never sees mem_ack is abandoned after TIMEOUT cycles
// and raises a sticky error flag.
//
// Ports:
//   clk, reset_n            clock (posedge) and asynchronous active-low reset
//   req_valid / req_ready   request handshake from decode
//   req_is_store, req_reg,
//   req_addr, req_wdata     request fields, captured on acceptance
//   mem_en, mem_we,
//   mem_addr, mem_wdata     memory request, held constant while in MEM
//   mem_rdata, mem_ack      memory response
//   memLoad, reg_sel,
//   write_data              register file write port, strobe is one cycle
//   done                    one-cycle pulse on successful completion
//   err, err_clr            sticky timeout flag and its clear
//
// Every output is either a flop or a decode of the state register, so there
// is no combinational path from any input to any output.

module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_reg,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              memLoad,
    output logic [2:0]        reg_sel,
    output logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Counter value on the last MEM cycle before giving up.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;

    logic              is_store_q;
    logic [2:0]        reg_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        cnt;
    logic              store_done;
    logic [2:0]        reg_sel_q;
    logic [DATA_W-1:0] write_data_q;
    logic              err_q;

    logic              accept;
    logic              ack_hit;
    logic              timeout_hit;

    assign accept      = (state == S_IDLE) && req_valid;
    assign ack_hit     = (state == S_MEM) && mem_ack;
    // An ack on the final allowed cycle takes priority over the timeout.
    assign timeout_hit = (state == S_MEM) && !mem_ack && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = S_MEM;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_next = is_store_q ? S_IDLE : S_WB;
                end else if (cnt == TO_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_WB: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, timeout counter, writeback registers and error flag.
    // reg_sel/write_data are only updated by a load ack so they hold their
    // value between loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_q   <= 1'b0;
            reg_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt          <= 8'd0;
            store_done   <= 1'b0;
            reg_sel_q    <= 3'd0;
            write_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            store_done <= ack_hit && is_store_q;

            if (accept) begin
                is_store_q <= req_is_store;
                reg_q      <= req_reg;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                cnt        <= 8'd0;
            end else if ((state == S_MEM) && !mem_ack) begin
                cnt <= cnt + 8'd1;
            end

            if (ack_hit && !is_store_q) begin
                reg_sel_q    <= reg_q;
                write_data_q <= mem_rdata;
            end

            // Setting on a timeout beats a simultaneous clear.
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign mem_en     = (state == S_MEM);
    assign mem_we     = (state == S_MEM) && is_store_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign memLoad    = (state == S_WB);
    assign reg_sel    = reg_sel_q;
    assign write_data = write_data_q;
    assign done       = (state == S_WB) || store_done;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. The stimulus thread issues requests and
// plays the memory, pushing the completion it expects into a scoreboard
// queue. A monitor on the falling edge pops an entry whenever the unit
// reports a completion (done, memLoad or a new err) and compares it.

module tb_mem_access_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    localparam int K_LOAD    = 0;
    localparam int K_STORE   = 1;
    localparam int K_TIMEOUT = 2;

    typedef struct {
        int          kind;
        logic [2:0]  rsel;
        logic [15:0] data;
        logic        exp_err;
    } expect_t;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_reg;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              memLoad;
    logic [2:0]        reg_sel;
    logic [DATA_W-1:0] write_data;
    logic              done;
    logic              err;
    logic              err_clr;

    int      checks = 0;
    int      errors = 0;
    expect_t sb[$];
    expect_t mon_e;
    logic    err_prev = 1'b0;

    mem_access_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_is_store(req_is_store),
        .req_reg     (req_reg),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .memLoad     (memLoad),
        .reg_sel     (reg_sel),
        .write_data  (write_data),
        .done        (done),
        .err         (err),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExpect(input int kind, input logic [2:0] rsel,
                              input logic [15:0] data, input logic exp_err);
        expect_t e;
        e.kind    = kind;
        e.rsel    = rsel;
        e.data    = data;
        e.exp_err = exp_err;
        sb.push_back(e);
    endtask

    // Present a request and wait (bounded) until it is accepted. Returns #1
    // after the accepting edge, i.e. in the first MEM cycle.
    task automatic issueRequest(input logic st, input logic [2:0] r,
                                input logic [15:0] a, input logic [15:0] d);
        int guard = 0;
        req_valid    = 1'b1;
        req_is_store = st;
        req_reg      = r;
        req_addr     = a;
        req_wdata    = d;
        while (!req_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Play the memory while mem_en is high; ack after ack_after idle cycles
    // (negative means never). Checks the memory interface every cycle.
    task automatic runMem(input logic st, input logic [15:0] a, input logic [15:0] d,
                          input int ack_after, input logic [15:0] rdata, input int exp_cycles);
        int n = 0;
        while (mem_en && n < TIMEOUT + 5) begin
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, st});
            checkOutput("mem_addr", {16'd0, mem_addr}, {16'd0, a});
            if (st) checkOutput("mem_wdata", {16'd0, mem_wdata}, {16'd0, d});
            checkOutput("req_ready_in_mem", {31'd0, req_ready}, 32'd0);
            mem_ack   = (n == ack_after);
            mem_rdata = (n == ack_after) ? rdata : 16'hDEAD;
            @(posedge clk);
            #1;
            n++;
        end
        mem_ack = 1'b0;
        checkOutput("mem_en_cycles", n, exp_cycles);
    endtask

    // One full access: expectation, request, memory phase, and a check that
    // the completion pulses have dropped one cycle later.
    task automatic applyStimulus(input logic st, input logic [2:0] r, input logic [15:0] a,
                                 input logic [15:0] d, input int ack_after,
                                 input logic [15:0] rdata, input logic exp_err);
        logic ok;
        int   exp_cycles;
        ok         = (ack_after >= 0) && (ack_after < TIMEOUT);
        exp_cycles = ok ? ack_after + 1 : TIMEOUT;
        if (!ok)     pushExpect(K_TIMEOUT, 3'd0, 16'd0, 1'b1);
        else if (st) pushExpect(K_STORE, 3'd0, 16'd0, exp_err);
        else         pushExpect(K_LOAD, r, rdata, exp_err);
        issueRequest(st, r, a, d);
        runMem(st, a, d, ack_after, rdata, exp_cycles);
        if (ok && !st) checkOutput("wb_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_after", {31'd0, done}, 32'd0);
        checkOutput("memLoad_after", {31'd0, memLoad}, 32'd0);
        checkOutput("mem_en_after", {31'd0, mem_en}, 32'd0);
        checkOutput("req_ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    // Monitor: every completion the unit reports must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            err_prev = 1'b0;
        end else begin
            if (done || memLoad || (err && !err_prev)) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", {29'd0, done, memLoad, err}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    case (mon_e.kind)
                        K_LOAD: begin
                            checkOutput("load_done", {31'd0, done}, 32'd1);
                            checkOutput("load_memLoad", {31'd0, memLoad}, 32'd1);
                            checkOutput("load_reg_sel", {29'd0, reg_sel}, {29'd0, mon_e.rsel});
                            checkOutput("load_write_data", {16'd0, write_data}, {16'd0, mon_e.data});
                            checkOutput("load_err", {31'd0, err}, {31'd0, mon_e.exp_err});
                        end
                        K_STORE: begin
                            checkOutput("store_done", {31'd0, done}, 32'd1);
                            checkOutput("store_memLoad", {31'd0, memLoad}, 32'd0);
                            checkOutput("store_err", {31'd0, err}, {31'd0, mon_e.exp_err});
                        end
                        default: begin
                            checkOutput("timeout_err", {31'd0, err}, 32'd1);
                            checkOutput("timeout_done", {31'd0, done}, 32'd0);
                            checkOutput("timeout_memLoad", {31'd0, memLoad}, 32'd0);
                        end
                    endcase
                end
            end
            err_prev = err;
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        checkOutput({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        checkOutput({tag, "_memLoad"}, {31'd0, memLoad}, 32'd0);
        checkOutput({tag, "_reg_sel"}, {29'd0, reg_sel}, 32'd0);
        checkOutput({tag, "_write_data"}, {16'd0, write_data}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_reg      = 3'd0;
        req_addr     = 16'd0;
        req_wdata    = 16'd0;
        mem_rdata    = 16'd0;
        mem_ack      = 1'b0;
        err_clr      = 1'b0;

        // Reset values.
        #3;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Load r3 from 0x0040, ack after two wait cycles, data 0xBEEF.
        $display("[TB] load with two wait cycles");
        applyStimulus(1'b0, 3'd3, 16'h0040, 16'h0000, 2, 16'hBEEF, 1'b0);

        // Store 0x1234 to 0x0010, ack in the first MEM cycle.
        $display("[TB] store with immediate ack");
        applyStimulus(1'b1, 3'd0, 16'h0010, 16'h1234, 0, 16'h0000, 1'b0);
        checkOutput("hold_reg_sel", {29'd0, reg_sel}, 32'd3);
        checkOutput("hold_write_data", {16'd0, write_data}, 32'h0000BEEF);

        // Load with no ack: abort after TIMEOUT cycles.
        $display("[TB] load timeout");
        applyStimulus(1'b0, 3'd5, 16'h0080, 16'h0000, -1, 16'h0000, 1'b0);
        checkOutput("timeout_err_sticky", {31'd0, err}, 32'd1);
        checkOutput("timeout_keeps_reg_sel", {29'd0, reg_sel}, 32'd3);

        // A second timeout with err_clr held: the set on the timeout edge
        // wins, then the held clear drops err on the following edge.
        $display("[TB] timeout with err_clr held");
        err_clr = 1'b1;
        applyStimulus(1'b1, 3'd0, 16'h0090, 16'h7777, -1, 16'h0000, 1'b0);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        err_clr = 1'b0;

        // Ack on the last allowed MEM cycle completes normally.
        $display("[TB] ack on timeout boundary");
        applyStimulus(1'b0, 3'd6, 16'h0100, 16'h0000, TIMEOUT - 1, 16'h5A5A, 1'b0);
        checkOutput("boundary_err", {31'd0, err}, 32'd0);

        // Second request held on req_valid during the first access.
        $display("[TB] held request during access");
        pushExpect(K_LOAD, 3'd1, 16'h1111, 1'b0);
        issueRequest(1'b0, 3'd1, 16'h0200, 16'h0000);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_reg      = 3'd2;
        req_addr     = 16'h0300;
        req_wdata    = 16'hCAFE;
        runMem(1'b0, 16'h0200, 16'h0000, 1, 16'h1111, 2);
        checkOutput("held_wb_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("held_wb_memLoad", {31'd0, memLoad}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("held_idle_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("held_idle_mem_en", {31'd0, mem_en}, 32'd0);
        pushExpect(K_STORE, 3'd0, 16'd0, 1'b0);
        issueRequest(1'b1, 3'd2, 16'h0300, 16'hCAFE);
        runMem(1'b1, 16'h0300, 16'hCAFE, 0, 16'h0000, 1);
        @(posedge clk);
        #1;
        checkOutput("held_done_after", {31'd0, done}, 32'd0);

        // Spurious ack while idle changes nothing.
        $display("[TB] spurious ack in idle");
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("spur_req_ready", {31'd0, req_ready}, 32'd1);
            checkOutput("spur_mem_en", {31'd0, mem_en}, 32'd0);
            checkOutput("spur_memLoad", {31'd0, memLoad}, 32'd0);
        end
        mem_ack = 1'b0;
        checkOutput("spur_reg_sel", {29'd0, reg_sel}, 32'd1);
        checkOutput("spur_write_data", {16'd0, write_data}, 32'h00001111);

        // Reset in the middle of a load.
        $display("[TB] reset during load");
        issueRequest(1'b0, 3'd7, 16'h0400, 16'h0000);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_mem_en", {31'd0, mem_en}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_reset_memLoad", {31'd0, memLoad}, 32'd0);
            checkOutput("post_reset_mem_en", {31'd0, mem_en}, 32'd0);
        end
        mem_ack = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store sequencer between instruction decode and data memory.
- Accepts one request at a time and runs the memory handshake.
- For loads, drives the register file write port (memLoad, reg_sel, write_data) for exactly one cycle.
- For stores, sends the register value to memory. Aborts a hung access on a timeout and flags the error.

Parameters:
- DATA_W, 16, data width of register file and memory.
- ADDR_W, 16, memory address width.
- TIMEOUT, 15, max cycles in MEM without mem_ack before abort (legal 1..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  decode presents a request.
- req_ready  out  1  unit can accept; transfer when req_valid && req_ready at posedge.
- req_is_store  in  1  1=store, 0=load.
- req_reg  in  3  destination (load) register index.
- req_addr  in  ADDR_W  memory address.
- req_wdata  in  DATA_W  store data (register value).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  ADDR_W  address, valid with mem_en.
- mem_wdata  out  DATA_W  store data, valid with mem_en && mem_we.
- mem_rdata  in  DATA_W  read data, valid with mem_ack on loads.
- mem_ack  in  1  memory completion.
- memLoad  out  1  register file write strobe.
- reg_sel  out  3  register index for the write.
- write_data  out  DATA_W  data for the write.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - Outputs at reset: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, memLoad=0, reg_sel=0, write_data=0, done=0, err=0.
  - Timeout counter=0. req_ready=1 after reset.
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- Outputs are stable before the falling edge, which is where the register file samples.
- IDLE:
  - req_ready=1.
  - On an accepted request: latch is_store, reg, addr, wdata; clear counter; go to MEM.
- MEM:
  - req_ready=0. mem_en=1, mem_we=latched is_store, mem_addr and mem_wdata held constant.
  - mem_ack is sampled at each posedge in MEM, including the first.
  - Load, ack=1: write_data<=mem_rdata, reg_sel<=latched reg; go to WB.
  - Store, ack=1: done=1 next cycle; go to IDLE.
  - ack=0 and counter==TIMEOUT-1: err<=1, no writeback, no done; go to IDLE.
  - ack=0 otherwise: counter+1.
  - mem_ack wins if it coincides with the timeout edge.
- WB (one cycle):
  - memLoad=1, done=1, mem_en=0, req_ready=0. Go to IDLE.
  - reg_sel and write_data hold their values until the next load's WB.
- mem_en drops in the cycle after ack. Back-to-back requests: the new request is accepted in IDLE, so there is a minimum of 1 idle cycle between accesses.
- Latency:
  - Load with ack on the first MEM cycle: accept edge, +1 ack edge, memLoad high for the following cycle. That is 3 posedges from accept to memLoad fall.
  - Store: done pulses 1 cycle after ack.
- Ignored inputs:
  - mem_ack in IDLE or WB: ignored.
  - req_valid while req_ready=0: ignored; decode must hold it.
- err: set on timeout, cleared by err_clr. If a timeout and err_clr occur on the same edge, set wins. err does not block new requests.
- Reset mid-operation: immediate abort, all outputs to reset values. A pending load is never written back.

Test Plan:
- Load reg3 from 0x0040; memory acks 2 cycles after mem_en with rdata=0xBEEF -> memLoad high exactly 1 cycle, reg_sel=3, write_data=0xBEEF, done=1 that cycle, err=0.
- Store 0x1234 to 0x0010; ack on the first MEM cycle -> mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234 for 1 cycle, done pulse next cycle, memLoad never asserted.
- Load with no ack (TIMEOUT=15) -> mem_en high exactly 15 cycles, then err=1, no memLoad, no done, req_ready=1. err_clr -> err=0.
- Ack on the 15th MEM cycle (timeout boundary) -> normal load completion, err stays 0.
- req_valid held during MEM, spurious mem_ack in IDLE -> second request accepted only in the IDLE cycle after completion; spurious ack causes no state change.
- reset_n pulsed low mid-MEM of a load -> all outputs 0 immediately, no memLoad after release, req_ready=1.
